// File: rtl/cic_frame_buffer.sv
// cic_frame_buffer: rounds, shifts and saturates CIC samples, captures triggered frames into a ping-pong buffer, streams them out
module cic_frame_buffer #(
    parameter int IN_WIDTH   = 44,
    parameter int OUT_WIDTH  = 16,
    parameter int SHIFT      = 20,
    parameter int FRAME_LEN  = 256,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  din,
    input  logic                 din_rdy,
    input  logic                 trig,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last,
    output logic                 sat,
    output logic                 overflow
);
    typedef enum logic {W_IDLE, W_FILL} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_PREFETCH, R_STREAM} r_state_t;

    localparam logic signed [IN_WIDTH:0] RND  = (IN_WIDTH+1)'(1) << (SHIFT-1);
    localparam logic signed [IN_WIDTH:0] MAXV = ((IN_WIDTH+1)'(1) << (OUT_WIDTH-1)) - 1'b1;
    localparam logic signed [IN_WIDTH:0] MINV = ~MAXV;
    localparam logic [ADDR_WIDTH-1:0]    LAST = ADDR_WIDTH'(FRAME_LEN-1);

    logic [OUT_WIDTH-1:0]  mem [2][FRAME_LEN];
    logic [OUT_WIDTH-1:0]  rdata_q;
    logic signed [IN_WIDTH:0] sum, r;
    logic                  clip_hi, clip_lo;
    logic [OUT_WIDTH-1:0]  s_data_d, s_data_q;
    logic                  s_rdy_d, s_rdy_q, sat_d, sat_q;
    w_state_t              w_state_d, w_state_q;
    r_state_t              r_state_d, r_state_q;
    logic [ADDR_WIDTH-1:0] waddr_d, waddr_q, raddr_d, raddr_q, rd_addr;
    logic                  wbank_d, wbank_q, rbank_d, rbank_q;
    logic [1:0]            full_d, full_q, set_full, clr_full;
    logic                  overflow_d, overflow_q, wr_en, fire;

    // scale: round half up, arithmetic shift, clip to output range
    always_comb begin
        sum      = {din[IN_WIDTH-1], din} + RND;
        r        = sum >>> SHIFT;
        clip_hi  = r > MAXV;
        clip_lo  = r < MINV;
        s_data_d = clip_hi ? MAXV[OUT_WIDTH-1:0] : clip_lo ? MINV[OUT_WIDTH-1:0] : r[OUT_WIDTH-1:0];
        s_rdy_d  = din_rdy;
        sat_d    = din_rdy & (clip_hi | clip_lo);
    end

    // writer: arm on trig when the target bank is free, fill one frame, hand bank over
    always_comb begin
        w_state_d  = w_state_q;
        waddr_d    = waddr_q;
        wbank_d    = wbank_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        set_full   = 2'b00;
        if (w_state_q == W_IDLE && trig) begin
            if (!full_q[wbank_q]) begin
                w_state_d = W_FILL;
                waddr_d   = '0;
            end else begin
                overflow_d = 1'b1;
            end
        end
        if (w_state_q == W_FILL && s_rdy_q) begin
            wr_en   = 1'b1;
            waddr_d = waddr_q + 1'b1;
            if (waddr_q == LAST) begin
                set_full  = 2'b01 << wbank_q;
                wbank_d   = ~wbank_q;
                w_state_d = W_IDLE;
                waddr_d   = '0;
            end
        end
    end

    // reader: prefetch word 0, then stream; the RAM re-reads raddr on stalls so data holds
    always_comb begin
        r_state_d = r_state_q;
        raddr_d   = raddr_q;
        rbank_d   = rbank_q;
        clr_full  = 2'b00;
        rd_addr   = '0;
        m_valid   = r_state_q == R_STREAM;
        m_last    = m_valid && raddr_q == LAST;
        m_data    = m_valid ? rdata_q : '0;
        fire      = m_valid && m_ready;
        case (r_state_q)
            R_IDLE: begin
                raddr_d   = '0;
                r_state_d = full_q[rbank_q] ? R_PREFETCH : R_IDLE;
            end
            R_PREFETCH: r_state_d = R_STREAM;
            default: begin
                rd_addr = raddr_q + ADDR_WIDTH'(fire);
                raddr_d = rd_addr;
                if (fire && m_last) begin
                    clr_full  = 2'b01 << rbank_q;
                    rbank_d   = ~rbank_q;
                    r_state_d = R_IDLE;
                    raddr_d   = '0;
                end
            end
        endcase
        full_d = (full_q | set_full) & ~clr_full;
    end

    assign sat      = sat_q;
    assign overflow = overflow_q;

    // frame storage with registered read port
    always_ff @(posedge clk) begin
        if (wr_en) mem[wbank_q][waddr_q] <= s_data_q;
        rdata_q <= mem[rbank_q][rd_addr];
    end

    // state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s_data_q   <= '0;
            s_rdy_q    <= 1'b0;
            sat_q      <= 1'b0;
            w_state_q  <= W_IDLE;
            r_state_q  <= R_IDLE;
            waddr_q    <= '0;
            raddr_q    <= '0;
            wbank_q    <= 1'b0;
            rbank_q    <= 1'b0;
            full_q     <= 2'b00;
            overflow_q <= 1'b0;
        end else begin
            s_data_q   <= s_data_d;
            s_rdy_q    <= s_rdy_d;
            sat_q      <= sat_d;
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            waddr_q    <= waddr_d;
            raddr_q    <= raddr_d;
            wbank_q    <= wbank_d;
            rbank_q    <= rbank_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end
endmodule

// File: tb/tb_cic_frame_buffer.sv
// tb_cic_frame_buffer: directed checks of scaling, framing, backpressure, ping-pong, overflow and reset
module tb_cic_frame_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [43:0] din = '0;
    logic        din_rdy = 1'b0;
    logic        trig = 1'b0;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_last;
    logic        sat;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int got[$];
    bit got_last[$];
    int fire_cyc[$];
    bit prev_stall = 1'b0;
    logic [15:0] prev_data = '0;
    logic prev_last = 1'b0;

    cic_frame_buffer #(
        .IN_WIDTH(44), .OUT_WIDTH(16), .SHIFT(20), .FRAME_LEN(8), .ADDR_WIDTH(3)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .din_rdy(din_rdy), .trig(trig),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .sat(sat), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // handshake collector and stall-stability checker
    always @(negedge clk) begin
        cyc++;
        if (prev_stall) begin
            chk("stall_valid", m_valid, 1);
            chk("stall_data", m_data, prev_data);
            chk("stall_last", m_last, prev_last);
        end
        if (m_valid && m_ready && !rst) begin
            got.push_back(int'($signed(m_data)));
            got_last.push_back(m_last);
            fire_cyc.push_back(cyc);
        end
        prev_stall = m_valid && !m_ready && !rst;
        prev_data = m_data;
        prev_last = m_last;
    end

    task automatic trig_pulse();
        @(posedge clk); #1 trig = 1'b1;
        @(posedge clk); #1 trig = 1'b0;
    endtask

    task automatic send(input logic [43:0] v, input bit es);
        @(posedge clk); #1 din = v; din_rdy = 1'b1;
        @(posedge clk); #1 din_rdy = 1'b0;
        chk("sat", sat, es);
    endtask

    task automatic fill(input int base);
        trig_pulse();
        for (int i = 0; i < 8; i++) send(44'(base + i) << 20, 1'b0);
    endtask

    task automatic wait_items(input int n);
        int c = 0;
        while (got.size() < n && c < 500) begin
            @(posedge clk); #1;
            c++;
        end
        chk("item_count", got.size(), n);
    endtask

    task automatic check_frame(input string tag, input int base, input int idx0);
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_data"}, (got.size() > idx0 + i) ? got[idx0 + i] : -99999, base + i);
            chk({tag, "_last"}, (got.size() > idx0 + i) ? got_last[idx0 + i] : 1'b0, i == 7);
        end
    endtask

    initial begin
        logic [43:0] rv[8];
        int rexp[8];
        bit rsat[8];
        logic [15:0] pat;
        int c;
        rv   = '{44'sh180000, -44'sh180000, 44'sh7FFFF, 44'sh100_0000_0000,
                 -44'sh100_0000_0000, 44'sh80000, -44'sh80000, -44'sh80001};
        rexp = '{2, -1, 0, 32767, -32768, 1, 0, -1};
        rsat = '{0, 0, 0, 1, 1, 0, 0, 0};
        pat  = 16'b1011_0010_0110_1001;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", m_valid, 0);
        chk("rst_last", m_last, 0);
        chk("rst_data", m_data, 0);
        chk("rst_sat", sat, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b0;

        // rounding and saturation
        m_ready = 1'b1;
        trig_pulse();
        for (int i = 0; i < 8; i++) send(rv[i], rsat[i]);
        wait_items(8);
        for (int i = 0; i < 8; i++) chk("round", (got.size() > i) ? got[i] : -99999, rexp[i]);

        // single frame latency and back-to-back streaming
        repeat (4) @(posedge clk);
        #1 got.delete();
        got_last.delete();
        fill(1);
        @(posedge clk); #1 chk("lat_e1", m_valid, 0);
        @(posedge clk); #1 chk("lat_e2", m_valid, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            chk("t2_valid", m_valid, 1);
            chk("t2_data", m_data, i + 1);
            chk("t2_last", m_last, i == 7);
            @(posedge clk); #1;
        end
        chk("t2_after", m_valid, 0);

        // backpressure
        m_ready = 1'b0;
        got.delete();
        got_last.delete();
        fill(101);
        c = 0;
        while (got.size() < 8 && c < 400) begin
            @(posedge clk); #1 m_ready = pat[c % 16];
            c++;
        end
        m_ready = 1'b0;
        chk("t3_count", got.size(), 8);
        check_frame("t3", 101, 0);

        // ping-pong: second frame captured while first is held
        repeat (4) @(posedge clk);
        #1 got.delete();
        got_last.delete();
        fire_cyc.delete();
        fill(11);
        fill(21);
        repeat (2) @(posedge clk);
        #1;
        chk("t4_ovf", overflow, 0);
        chk("t4_hold_valid", m_valid, 1);
        chk("t4_hold_data", m_data, 11);
        m_ready = 1'b1;
        wait_items(16);
        check_frame("t4a", 11, 0);
        check_frame("t4b", 21, 8);
        chk("t4_nobubble", (fire_cyc.size() > 1) ? fire_cyc[1] - fire_cyc[0] : -1, 1);
        chk("t4_gap", (fire_cyc.size() > 8) ? fire_cyc[8] - fire_cyc[7] : -1, 3);
        chk("t4_ovf_end", overflow, 0);

        // overflow: third frame dropped while both banks are full
        m_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 got.delete();
        got_last.delete();
        fill(31);
        fill(41);
        trig_pulse();
        chk("t5_ovf", overflow, 1);
        for (int i = 0; i < 8; i++) send(44'(51 + i) << 20, 1'b0);
        chk("t5_hold", m_data, 31);
        m_ready = 1'b1;
        wait_items(16);
        check_frame("t5a", 31, 0);
        check_frame("t5b", 41, 8);
        repeat (40) @(posedge clk);
        #1 chk("t5_no_extra", got.size(), 16);

        // reset while streaming sample 4
        m_ready = 1'b0;
        fill(61);
        c = 0;
        while (!m_valid && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        chk("t6_valid", m_valid, 1);
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 m_ready = 1'b0;
        chk("t6_sample4", m_data, 64);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_valid0", m_valid, 0);
        chk("t6_last0", m_last, 0);
        chk("t6_data0", m_data, 0);
        chk("t6_sat0", sat, 0);
        chk("t6_ovf0", overflow, 0);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1 chk("t6_full_clear", m_valid, 0);
        got.delete();
        got_last.delete();
        m_ready = 1'b1;
        fill(71);
        wait_items(8);
        check_frame("t6", 71, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cic_frame_buffer.md
# cic_frame_buffer

Sits directly downstream of the CIC decimator (44-bit output, one-cycle `rdy` strobe per decimated sample). Rescales each CIC sample by an arithmetic right shift with rounding, then saturates it to the pulse-compression word width. Captures one range line per trigger into a ping-pong buffer and streams completed frames to the pulse-compression FFT over a valid/ready interface with an end-of-frame marker.

## Interface
- `IN_WIDTH`, 44, CIC output width.
- `OUT_WIDTH`, 16, output sample width (signed).
- `SHIFT`, 20, CIC gain removal, as a right shift (≥1).
- `FRAME_LEN`, 256, samples per frame (≥2).
- `ADDR_WIDTH`, 8, ≥ clog2(FRAME_LEN).
- One clock; reset is synchronous and active-high.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `din`  in  IN_WIDTH  signed CIC sample; valid only when `din_rdy`=1.
- `din_rdy`  in  1  one-cycle sample strobe from the CIC.
- `trig`  in  1  one-cycle pulse; arms capture of one frame.
- `m_data`  out  OUT_WIDTH  signed output sample.
- `m_valid`  out  1  `m_data` valid.
- `m_ready`  in  1  consumer accepts when `m_valid`&&`m_ready`.
- `m_last`  out  1  qualifies the final sample of a frame.
- `sat`  out  1  one-cycle pulse: the current scaled sample was clipped.
- `overflow`  out  1  sticky: a frame was dropped because no bank was free.

## Operation
- **Scale stage** (registered, latency 1):
  - Compute `r = (din + 2^(SHIFT-1)) >>> SHIFT` at IN_WIDTH+1 bits. Rounding is round-half-up, so ties round toward +inf.
  - Clip `r` to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Register the clipped value as `s_data`, with strobe `s_rdy` = delayed `din_rdy`.
  - `sat` pulses with `s_rdy` whenever clipping occurred.
- **Storage:** two banks of FRAME_LEN×OUT_WIDTH with synchronous read. Each bank has a `full[b]` flag.
- **Write FSM:**
  - W_IDLE:
    - On `trig`: if `full[wbank]`=0, go to W_FILL with `waddr`=0.
    - Otherwise set `overflow` and stay in W_IDLE; that frame is dropped.
  - W_FILL:
    - On each `s_rdy`, write `s_data` to `wbank[waddr]` and increment `waddr`.
    - The write at `waddr`=FRAME_LEN-1 sets `full[wbank]`, toggles `wbank`, and returns to W_IDLE.
    - `trig` is ignored while in W_FILL.
  - An `s_rdy` that arrives in the same cycle as the arming `trig` is not written.
  - `s_rdy` while in W_IDLE is discarded.
- **Read FSM:**
  - R_IDLE: if `full[rbank]`, go to R_PREFETCH; the read address is 0.
  - R_PREFETCH: one cycle, then go to R_STREAM.
  - R_STREAM:
    - `m_valid`=1 and `m_data` = RAM output register.
    - Read address each cycle is `raddr + (fire ? 1 : 0)`, where fire = `m_valid`&&`m_ready`.
    - `m_last`=1 when `raddr`=FRAME_LEN-1.
    - On fire with `m_last`: clear `full[rbank]`, toggle `rbank`, go to R_IDLE.
- **Flag updates:** the writer sets `full` and the reader clears it. Both can act in the same cycle only on different banks; each update applies independently.
- **Stall rule:** `m_data` and `m_last` stay stable while `m_valid`=1 and `m_ready`=0.
- **Reset** (any state, including mid-fill or mid-stream):
  - FSMs go to IDLE.
  - `wbank`=`rbank`=0, `full`=00.
  - `waddr`=`raddr`=0.
  - Outputs: `m_valid`=0, `m_last`=0, `m_data`=0, `sat`=0, `overflow`=0.
  - Partially captured data is discarded.

## Timing
- `din_rdy` at cycle t → `s_rdy` at t+1 → RAM write at the end of t+1.
- Last sample of a frame written at edge E → `full` visible in cycle E+1 → R_PREFETCH in E+2 → first `m_valid` in E+3.
- With `m_ready` held at 1, a frame streams with `m_valid` high for FRAME_LEN consecutive cycles and no bubbles.
- After the final handshake, `m_valid`=0 for at least 2 cycles (R_IDLE, R_PREFETCH) before the next frame.
- Throughput: one input sample per cycle is supported. The CIC delivers one sample every 10 cycles.

## Test plan
1. **Rounding/saturation.** SHIFT=20.
   - `din`=0x180000 → stored 2.
   - `din`=-0x180000 → -1.
   - `din`=0x7FFFF → 0.
   - `din`=2^40 → 32767 with `sat` pulse.
   - `din`=-2^40 → -32768 with `sat` pulse.
2. **Single frame.** FRAME_LEN=8, `trig`, then 8 strobes of ramp 1..8 (scaled) with `m_ready`=1 → outputs 1..8 in order on 8 consecutive cycles, `m_last` only on 8; first `m_valid` 3 cycles after the 8th write.
3. **Backpressure.** `m_ready` driven by a pseudo-random pattern → exactly 8 handshakes in order, no duplicates or losses; `m_data` stable across stalls.
4. **Ping-pong.** Second `trig` and frame captured while frame 1 is held by `m_ready`=0 → frame 2 lands in bank 1; it streams immediately after frame 1's `m_last`; `overflow` stays 0.
5. **Overflow.** Both banks full, `m_ready`=0, third `trig` plus 8 strobes → `overflow`=1; on release, only frames 1 and 2 are output.
6. **Reset mid-stream.** `rst` asserted while `m_valid`=1 at sample 4 → all outputs 0 the next cycle, `full`=00; a new `trig` plus frame then streams normally from sample 1.
